// File: rtl/reset_boot_sequencer_if.sv
// Boot sequencer bus: software reset request, IMEM read port and core-facing
// reset/PC-load outputs. master = sequencer, slave = core/memory side.
`timescale 1ns/1ps
interface reset_boot_sequencer_if;
    logic       sw_rst_req;
    logic [7:0] imem_data;
    logic       imem_rd;
    logic [7:0] imem_addr;
    logic       core_rst_n;
    logic       pc_load;
    logic [7:0] pc_value;
    logic       boot_done;

    modport master (
        input  sw_rst_req, imem_data,
        output imem_rd, imem_addr, core_rst_n, pc_load, pc_value, boot_done
    );
    modport slave (
        output sw_rst_req, imem_data,
        input  imem_rd, imem_addr, core_rst_n, pc_load, pc_value, boot_done
    );
endinterface

// File: rtl/reset_boot_sequencer.sv
// Reset/boot sequencer: synchronizes reset release, stretches core reset,
// fetches the reset vector from IMEM and loads it into the core PC.
`timescale 1ns/1ps
module reset_boot_sequencer #(
    parameter int         STRETCH_CYCLES = 4,
    parameter int         MEM_LATENCY    = 1,
    parameter logic [7:0] VECTOR_ADDR    = 8'h00
) (
    input  logic                          clk,
    input  logic                          rst_n,
    reset_boot_sequencer_if.master        bus
);
    typedef enum logic [2:0] {
        S_HOLD, S_STRETCH, S_FETCH, S_WAIT, S_LOAD, S_RUN
    } state_t;

    state_t     state;
    logic [1:0] sync;
    logic [7:0] cnt;
    logic       rst_sync;

    // Release is synchronized; assertion clears the flops asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync <= 2'b00;
        else        sync <= {sync[0], 1'b1};
    end
    assign rst_sync      = sync[1];
    assign bus.imem_addr = VECTOR_ADDR;

    // Outputs are registered: each transition sets the values of the state entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_HOLD;
            cnt            <= 8'd0;
            bus.imem_rd    <= 1'b0;
            bus.core_rst_n <= 1'b0;
            bus.pc_load    <= 1'b0;
            bus.pc_value   <= 8'h00;
            bus.boot_done  <= 1'b0;
        end else begin
            case (state)
                S_HOLD: begin
                    if (rst_sync) begin
                        state <= S_STRETCH;
                        cnt   <= 8'd0;
                    end
                end
                S_STRETCH: begin
                    if (cnt == 8'(STRETCH_CYCLES - 1)) begin
                        state       <= S_FETCH;
                        cnt         <= 8'd0;
                        bus.imem_rd <= 1'b1;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                S_FETCH: begin
                    state       <= S_WAIT;
                    cnt         <= 8'd0;
                    bus.imem_rd <= 1'b0;
                end
                S_WAIT: begin
                    if (cnt == 8'(MEM_LATENCY - 1)) begin
                        state        <= S_LOAD;
                        cnt          <= 8'd0;
                        bus.pc_value <= bus.imem_data;
                        bus.pc_load  <= 1'b1;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                S_LOAD: begin
                    state          <= S_RUN;
                    bus.pc_load    <= 1'b0;
                    bus.core_rst_n <= 1'b1;
                    bus.boot_done  <= 1'b1;
                end
                S_RUN: begin
                    // Warm reset keeps pc_value until the next capture.
                    if (bus.sw_rst_req) begin
                        state          <= S_STRETCH;
                        cnt            <= 8'd0;
                        bus.core_rst_n <= 1'b0;
                        bus.boot_done  <= 1'b0;
                    end
                end
                default: begin
                    state <= S_HOLD;
                    cnt   <= 8'd0;
                end
            endcase
        end
    end
endmodule
